// File: rtl/aximem_loader.sv
`default_nettype none
// ============================================================================
// Module   : aximem_loader
// Brief    : Packs a byte stream into little-endian 32-bit words and writes
//            them to unified memory while holding the core in reset.
// Revision : 1.0
// ============================================================================
module aximem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned NUM_WORDS = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    input  logic [7:0]                       in_data,
    output logic                             in_ready,
    output logic                             axi_mem_w,
    output logic [31:0]                      axi_mem_addr,
    output logic [31:0]                      axi_mem_data,
    output logic                             busy,
    output logic                             done,
    output logic                             hold_cpu,
    output logic [$clog2(NUM_WORDS+1)-1:0]   words_written
);

    localparam int unsigned WCW = $clog2(NUM_WORDS + 1);
    localparam logic [WCW-1:0] c_NUM_WORDS = WCW'(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_byte_cnt;
    logic [23:0]      r_shift;
    logic [WCW-1:0]   r_words;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;

    logic [WCW-1:0]   w_words_next;
    logic [31:0]      w_addr_next;

    // The word index always equals the number of writes already issued.
    assign w_words_next = r_words + WCW'(1);
    assign w_addr_next  = BASE_ADDR + (32'(r_words) << 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_words    <= '0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_COLLECT;
                        r_byte_cnt <= 2'd0;
                        r_words    <= '0;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_byte_cnt <= 2'd0;
                    end else if (in_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_shift[7:0]   <= in_data;
                            2'd1:    r_shift[15:8]  <= in_data;
                            2'd2:    r_shift[23:16] <= in_data;
                            default: begin
                                r_state <= S_WRITE;
                                r_addr  <= w_addr_next;
                                r_data  <= {in_data, r_shift};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    // The strobe in this cycle always counts, even when aborted.
                    r_words <= w_words_next;
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_words_next == c_NUM_WORDS) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == S_COLLECT);
    assign axi_mem_w     = (r_state == S_WRITE);
    assign busy          = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign done          = (r_state == S_DONE);
    assign hold_cpu      = (r_state != S_DONE);
    assign axi_mem_addr  = r_addr;
    assign axi_mem_data  = r_data;
    assign words_written = r_words;

endmodule
`default_nettype wire
